// File: rtl/spi_trig_pkg.sv
// Shared types, default parameters and bit-vector helpers for the SPI trigger
// sequencer.
package spi_trig_pkg;

    localparam int unsigned DEF_N_TRIG  = 4;
    localparam int unsigned DEF_PEND_W  = 4;
    localparam int unsigned DEF_BURST_W = 8;
    localparam int unsigned DEF_GAP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_GAP   = 2'd3
    } trig_state_t;

    // Number of set bits; sized for the largest supported trigger vector.
    function automatic logic [4:0] f_popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [3:0] f_lowest16(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for a vector of
// asynchronous trigger lines.
module trig_sync_edge #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;
    logic [W-1:0] r_rise;
    logic [1:0]   r_warm;

    // Edges are suppressed until the pipeline holds real samples, so lines
    // already high when reset releases never look like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {W{1'b0}};
            r_sync <= {W{1'b0}};
            r_prev <= {W{1'b0}};
            r_rise <= {W{1'b0}};
            r_warm <= 2'd0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end else begin
                r_warm <= r_warm;
            end
            r_rise <= (r_warm == 2'd3) ? (r_sync & ~r_prev) : {W{1'b0}};
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/spi_trig_seq.sv
// Trigger-driven SPI word sequencer: counts accepted trigger events and issues
// one burst of data-valid pulses to an SPI master per pending event.
module spi_trig_seq
    import spi_trig_pkg::*;
#(
    parameter int unsigned N_TRIG  = DEF_N_TRIG,
    parameter int unsigned PEND_W  = DEF_PEND_W,
    parameter int unsigned BURST_W = DEF_BURST_W,
    parameter int unsigned GAP_W   = DEF_GAP_W,
    localparam int unsigned SRC_W  = (N_TRIG > 1) ? $clog2(N_TRIG) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_TRIG-1:0]  trig,
    input  logic [N_TRIG-1:0]  trig_en,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [GAP_W-1:0]   gap_cyc,
    input  logic               i_TX_Ready,
    output logic               o_TX_DV,
    output logic [BURST_W-1:0] o_word_idx,
    output logic [SRC_W-1:0]   o_trig_src,
    output logic               o_busy,
    output logic               o_overflow,
    input  logic               clr_overflow
);

    localparam int unsigned CNT_W = PEND_W + 6;

    logic [N_TRIG-1:0] w_rise;
    logic [N_TRIG-1:0] w_evt;
    logic [15:0]       w_evt16;
    logic [4:0]        w_add;

    trig_state_t       r_state;
    trig_state_t       w_state_nxt;
    logic [PEND_W-1:0] r_pending;
    logic [PEND_W-1:0] w_pend_nxt;
    logic [CNT_W-1:0]  w_sum;
    logic [CNT_W-1:0]  w_max;
    logic              w_ovf;
    logic              w_dec;
    logic              w_start;
    logic              w_idx_inc;
    logic              w_gap_load;
    logic              w_gap_dec;

    logic [BURST_W-1:0] r_word_idx;
    logic [BURST_W-1:0] r_last_idx;
    logic [GAP_W-1:0]   r_gap_lat;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_ack_first;
    logic [SRC_W-1:0]   r_last_src;
    logic [SRC_W-1:0]   r_trig_src;
    logic               r_busy;
    logic               r_overflow;

    trig_sync_edge #(.W(N_TRIG)) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (trig),
        .o_rise  (w_rise)
    );

    assign w_evt   = w_rise & trig_en;
    assign w_evt16 = 16'(w_evt);
    assign w_add   = f_popcount16(w_evt16);

    // Pending counter next value: add all simultaneous events, net the burst
    // start, and clamp at the counter maximum.
    always_comb begin
        w_max = CNT_W'({PEND_W{1'b1}});
        w_sum = CNT_W'(r_pending) + CNT_W'(w_add) - CNT_W'(w_dec);
        w_ovf = (w_sum > w_max);
        if (w_ovf) begin
            w_pend_nxt = {PEND_W{1'b1}};
        end else begin
            w_pend_nxt = w_sum[PEND_W-1:0];
        end
    end

    // FSM next-state and datapath control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_dec       = 1'b0;
        w_start     = 1'b0;
        w_idx_inc   = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_pending != {PEND_W{1'b0}}) && i_TX_Ready) begin
                    w_state_nxt = ST_ISSUE;
                    w_dec       = 1'b1;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i_TX_Ready) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ACK: begin
                // The master still shows the stale ready in the first ACK cycle.
                if (r_ack_first || !i_TX_Ready) begin
                    w_state_nxt = ST_ACK;
                end else if (r_word_idx == r_last_idx) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_inc = 1'b1;
                    if (r_gap_lat == {GAP_W{1'b0}}) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_gap_load  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_GAP;
                    w_gap_dec   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending count, sticky overflow (a same-cycle set beats the clear) and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= {PEND_W{1'b0}};
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    // Burst parameters are captured at burst start so mid-burst edits wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_idx  <= {BURST_W{1'b0}};
            r_last_idx  <= {BURST_W{1'b0}};
            r_gap_lat   <= {GAP_W{1'b0}};
            r_gap_cnt   <= {GAP_W{1'b0}};
            r_ack_first <= 1'b0;
            r_last_src  <= {SRC_W{1'b0}};
            r_trig_src  <= {SRC_W{1'b0}};
        end else begin
            if (w_start) begin
                r_word_idx <= {BURST_W{1'b0}};
                r_last_idx <= (burst_len == {BURST_W{1'b0}}) ? {BURST_W{1'b0}}
                                                              : burst_len - BURST_W'(1);
                r_gap_lat  <= gap_cyc;
                r_trig_src <= r_last_src;
            end else if (w_idx_inc) begin
                r_word_idx <= r_word_idx + BURST_W'(1);
            end else begin
                r_word_idx <= r_word_idx;
            end
            if (w_gap_load) begin
                r_gap_cnt <= r_gap_lat;
            end else if (w_gap_dec) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end else begin
                r_gap_cnt <= r_gap_cnt;
            end
            r_ack_first <= (r_state == ST_ISSUE);
            if (w_evt != {N_TRIG{1'b0}}) begin
                r_last_src <= SRC_W'(f_lowest16(w_evt16));
            end else begin
                r_last_src <= r_last_src;
            end
        end
    end

    // DV is gated by the live ready so it can never fire while ready is low.
    assign o_TX_DV    = (r_state == ST_ISSUE) && i_TX_Ready;
    assign o_word_idx = r_word_idx;
    assign o_trig_src = r_trig_src;
    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_spi_trig_seq.sv
// Directed self-checking bench for spi_trig_seq with a simple SPI-master
// ready model that drops ready for two cycles after every DV.
module tb_spi_trig_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] trig;
    logic [3:0] trig_en;
    logic [7:0] burst_len;
    logic [7:0] gap_cyc;
    logic       i_TX_Ready;
    logic       o_TX_DV;
    logic [7:0] o_word_idx;
    logic [1:0] o_trig_src;
    logic       o_busy;
    logic       o_overflow;
    logic       clr_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int dv_count = 0;
    int dv_idx[$];
    int dv_src[$];
    int dv_cyc[$];
    bit hold_low = 1'b0;
    int drop_cnt = 0;
    bit seen_dv;
    int base;

    spi_trig_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig         (trig),
        .trig_en      (trig_en),
        .burst_len    (burst_len),
        .gap_cyc      (gap_cyc),
        .i_TX_Ready   (i_TX_Ready),
        .o_TX_DV      (o_TX_DV),
        .o_word_idx   (o_word_idx),
        .o_trig_src   (o_trig_src),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [3:0] m);
        trig = m;
        repeat (2) tick();
        trig = 4'd0;
        repeat (2) tick();
    endtask

    task automatic wait_dv(input int target, input int budget, input string tag);
        int k = 0;
        while (dv_count < target && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 32'(dv_count >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (o_busy && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_dv"},   32'(o_TX_DV),    32'd0);
        chk({tag, "_idx"},  32'(o_word_idx), 32'd0);
        chk({tag, "_src"},  32'(o_trig_src), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy),     32'd0);
        chk({tag, "_ovf"},  32'(o_overflow), 32'd0);
        chk({tag, "_pend"}, 32'(dut.r_pending), 32'd0);
    endtask

    // DV monitor: records each word and confirms ready accompanied it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_TX_DV === 1'b1) begin
                dv_count++;
                dv_idx.push_back(int'(o_word_idx));
                dv_src.push_back(int'(o_trig_src));
                dv_cyc.push_back(cyc);
                chk("dv_with_ready", 32'(i_TX_Ready), 32'd1);
            end
        end
    end

    // SPI master model: ready low for two cycles after each DV.
    initial begin
        i_TX_Ready = 1'b1;
        forever begin
            @(negedge clk);
            seen_dv = (o_TX_DV === 1'b1);
            @(posedge clk);
            #1;
            if (hold_low) begin
                i_TX_Ready = 1'b0;
                drop_cnt   = 0;
            end else if (seen_dv) begin
                i_TX_Ready = 1'b0;
                drop_cnt   = 2;
            end else if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 0) i_TX_Ready = 1'b1;
            end else begin
                i_TX_Ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        trig         = 4'b0001;
        trig_en      = 4'b1111;
        burst_len    = 8'd3;
        gap_cyc      = 8'd2;
        clr_overflow = 1'b0;
        repeat (3) tick();
        chk_outputs_zero("reset");

        // Trigger already high at release must not start a burst.
        rst_n = 1'b1;
        repeat (10) tick();
        trig = 4'b0000;
        repeat (5) tick();
        chk("release_high_dv", 32'(dv_count), 32'd0);
        chk("release_high_pend", 32'(dut.r_pending), 32'd0);

        // Single pulse on trig[2], 3 words, gap 2; mid-burst edits ignored.
        base = dv_count;
        pulse(4'b0100);
        wait_dv(base + 1, 50, "s1_first");
        burst_len = 8'd5;
        gap_cyc   = 8'd0;
        wait_dv(base + 3, 100, "s1_all");
        chk("s1_busy_after_dv3", 32'(o_busy), 32'd1);
        wait_idle(20, "s1");
        repeat (10) tick();
        chk("s1_count", 32'(dv_count - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("s1_idx", 32'(dv_idx[base + i]), 32'(i));
            chk("s1_src", 32'(dv_src[base + i]), 32'd2);
        end
        chk("s1_gap_latched", 32'(dv_cyc[base + 2] - dv_cyc[base + 1]), 32'd6);

        // Simultaneous events on trig[0] and trig[3].
        burst_len = 8'd1;
        gap_cyc   = 8'd0;
        hold_low  = 1'b1;
        repeat (2) tick();
        base = dv_count;
        pulse(4'b1001);
        repeat (6) tick();
        chk("s2_pending", 32'(dut.r_pending), 32'd2);
        hold_low = 1'b0;
        wait_dv(base + 2, 80, "s2");
        wait_idle(20, "s2");
        repeat (10) tick();
        chk("s2_count", 32'(dv_count - base), 32'd2);
        chk("s2_src0", 32'(dv_src[base]),     32'd0);
        chk("s2_src1", 32'(dv_src[base + 1]), 32'd0);
        chk("s2_idx1", 32'(dv_idx[base + 1]), 32'd0);

        // 20 events with ready low: saturate at 15 and flag overflow.
        hold_low = 1'b1;
        repeat (2) tick();
        base = dv_count;
        for (int i = 0; i < 20; i++) pulse(4'b0010);
        repeat (6) tick();
        chk("s3_pending_sat", 32'(dut.r_pending), 32'd15);
        chk("s3_ovf_set", 32'(o_overflow), 32'd1);
        chk("s3_no_dv", 32'(dv_count - base), 32'd0);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("s3_ovf_clr", 32'(o_overflow), 32'd0);
        hold_low = 1'b0;
        wait_dv(base + 15, 400, "s3");
        wait_idle(20, "s3");
        repeat (20) tick();
        chk("s3_count", 32'(dv_count - base), 32'd15);
        chk("s3_pend_empty", 32'(dut.r_pending), 32'd0);
        chk("s3_src", 32'(dv_src[base + 14]), 32'd1);

        // Disabled channel is ignored.
        trig_en = 4'b1011;
        base = dv_count;
        pulse(4'b0100);
        repeat (15) tick();
        chk("s4_no_dv", 32'(dv_count - base), 32'd0);
        chk("s4_pending", 32'(dut.r_pending), 32'd0);
        chk("s4_busy", 32'(o_busy), 32'd0);
        trig_en = 4'b1111;

        // Reset during the second word of a 4-word burst.
        burst_len = 8'd4;
        gap_cyc   = 8'd2;
        base = dv_count;
        pulse(4'b1000);
        wait_dv(base + 2, 80, "s5_pre");
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("s5_rst");
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("s5_aborted", 32'(dv_count - base), 32'd2);
        chk("s5_busy", 32'(o_busy), 32'd0);
        base = dv_count;
        pulse(4'b0010);
        wait_dv(base + 4, 150, "s5_post");
        wait_idle(20, "s5_post");
        for (int i = 0; i < 4; i++) begin
            chk("s5_idx", 32'(dv_idx[base + i]), 32'(i));
        end
        chk("s5_src", 32'(dv_src[base]), 32'd1);

        // burst_len 0 behaves as 1; gap 0 gives back-to-back words.
        burst_len = 8'd0;
        gap_cyc   = 8'd0;
        base = dv_count;
        pulse(4'b0001);
        wait_dv(base + 1, 50, "s6_len0");
        wait_idle(20, "s6_len0");
        repeat (10) tick();
        chk("s6_len0_count", 32'(dv_count - base), 32'd1);
        chk("s6_len0_idx", 32'(dv_idx[base]), 32'd0);
        burst_len = 8'd3;
        base = dv_count;
        pulse(4'b0001);
        wait_dv(base + 3, 80, "s6_b2b");
        wait_idle(20, "s6_b2b");
        repeat (10) tick();
        chk("s6_b2b_count", 32'(dv_count - base), 32'd3);
        chk("s6_b2b_sp1", 32'(dv_cyc[base + 1] - dv_cyc[base]),     32'd4);
        chk("s6_b2b_sp2", 32'(dv_cyc[base + 2] - dv_cyc[base + 1]), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_trig_seq.md
SPI_TRIG_SEQ -- requirements
Module: spi_trig_seq

Interface
REQ-001 The block SHALL have parameter N_TRIG, default 4, the number of trigger input channels (1..16).
REQ-002 The block SHALL have parameter PEND_W, default 4, the width of the pending-trigger counter.
REQ-003 The block SHALL have parameter BURST_W, default 8, the width of the burst-length input.
REQ-004 The block SHALL have parameter GAP_W, default 8, the width of the inter-word gap input.
REQ-005 Ports SHALL be, in this order:
  - clk  in  1  system clock; one clock; all logic on rising edge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - trig  in  N_TRIG  asynchronous trigger lines.
  - trig_en  in  N_TRIG  per-channel enable mask.
  - burst_len  in  BURST_W  words issued per accepted trigger; 0 is treated as 1.
  - gap_cyc  in  GAP_W  idle clk cycles between words of a burst.
  - i_TX_Ready  in  1  SPI master ready for a new word.
  - o_TX_DV  out  1  single-cycle data-valid pulse to the SPI master.
  - o_word_idx  out  BURST_W  index of the current word within the burst.
  - o_trig_src  out  clog2(N_TRIG) (min 1)  channel that started the current burst.
  - o_busy  out  1  high whenever state is not IDLE.
  - o_overflow  out  1  sticky; set when a trigger is lost.
  - clr_overflow  in  1  synchronous clear for o_overflow.

Function
REQ-006 Each trig bit SHALL pass through a 2-flop synchroniser followed by rising-edge detection, giving a 1-cycle event 3 cycles after the input edge.
REQ-007 Events on channels with trig_en=0 SHALL be discarded.
REQ-008 Accepted events SHALL increment a saturating pending counter, one increment per event; simultaneous events on k channels SHALL add k.
REQ-009 When the pending counter would exceed 2^PEND_W-1, the excess SHALL be dropped and o_overflow set.
REQ-010 A source FIFO-free policy SHALL apply: o_trig_src SHALL latch the lowest-numbered channel active in the event that starts a burst, or the lowest channel of the most recent event if the burst comes from the pending count.
REQ-011 The FSM SHALL have states IDLE, ISSUE, ACK, GAP.
REQ-012 IDLE: when pending>0 and i_TX_Ready=1, go to ISSUE; decrement pending; latch burst_len and gap_cyc; clear o_word_idx.
REQ-013 ISSUE: assert o_TX_DV for exactly one cycle, then go to ACK.
REQ-014 ACK: ignore i_TX_Ready in the first cycle, because the master drops ready the cycle after DV.
REQ-015 ACK, from the second cycle: on i_TX_Ready=1, go to IDLE if the word was the last; otherwise increment o_word_idx and go to GAP (or straight to ISSUE if the latched gap is 0).
REQ-016 GAP: count the latched gap cycles, then go to ISSUE.
REQ-017 o_TX_DV SHALL never be asserted while i_TX_Ready=0 in the same cycle; if ready is low in ISSUE, the FSM SHALL hold in ISSUE with DV low until ready=1.
REQ-018 An increment and a decrement of pending in the same cycle SHALL net correctly; a saturated counter with a simultaneous decrement SHALL accept one new event without overflow.
REQ-019 Changes to burst_len or gap_cyc during a burst SHALL take effect only at the next burst.
REQ-020 clr_overflow SHALL have priority below a same-cycle overflow set (set wins).

Reset
REQ-021 While rst_n=0 (asserted asynchronously):
  - all outputs SHALL be 0;
  - the FSM SHALL be in IDLE;
  - pending, synchronisers and edge registers SHALL be 0.
REQ-022 Release SHALL be synchronised externally; triggers high at release SHALL NOT produce events.
REQ-023 Reset mid-burst SHALL abort the burst with no further DV pulses.

Structure
REQ-024 A shared package spi_trig_pkg SHALL hold the FSM state enum (trig_state_t) and the default parameter constants.
REQ-025 A sub-module trig_sync_edge (2-flop synchroniser plus rising-edge detect, width-parametrised) SHALL be instantiated once for the full trig vector.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - Single pulse, N_TRIG=4, trig[2] rising, burst_len=3, gap_cyc=2, ready always re-asserting 2 cycles after DV -> 3 DV pulses; o_word_idx 0,1,2; o_trig_src=2; o_busy drops after the third ack.
  - trig[0] and trig[3] rising in the same cycle with burst_len=1 -> pending=2; two bursts; o_trig_src=0.
  - 20 events with PEND_W=4 while ready is held low -> pending saturates at 15; o_overflow=1; clr_overflow clears it; 15 DV pulses follow once ready goes high.
  - trig_en=4'b1011 with a pulse on trig[2] -> no DV, pending stays 0.
  - rst_n low for 1 cycle during the second word of a 4-word burst -> DV stops; all outputs 0; next trigger starts again at o_word_idx=0.
  - burst_len=0 and gap_cyc=0 -> exactly 1 DV per trigger, with back-to-back ISSUE after ACK for multi-word bursts.
